// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: sequences a two-input glitch-free clock mux.
// Requests from NREQ requesters are arbitrated round-robin. The granted
// target is driven onto the mux select, and the controller then follows the
// break-before-make handover through the synchronized per-path active flags.
// Each request gets a one-cycle ack, with err flagged if a wait step timed out.
// Everything runs on the always-on reference clock.

module clk_switch_ctrl #(
  parameter int NREQ        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_tgt,
  input  logic            act0,
  input  logic            act1,
  output logic            select,
  output logic [NREQ-1:0] ack,
  output logic            err,
  output logic            busy,
  output logic            cur_src
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BREAK = 2'd1,
    ST_MAKE  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  // Active flag of a source: src=1 is the clk0 path, src=0 the clk1 path.
  function automatic logic src_active(input logic src, input logic a0, input logic a1);
    src_active = src ? a0 : a1;
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    onehot      = {NREQ{1'b0}};
    onehot[idx] = 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] act0_sync_r;
  logic [SYNC_STAGES-1:0] act1_sync_r;
  logic                   act0_s;
  logic                   act1_s;

  state_t           state_r,  state_nx;
  logic             select_r, select_nx;
  logic [PTR_W-1:0] gnt_r,    gnt_nx;
  logic             tgt_r,    tgt_nx;
  logic [CNT_W-1:0] cnt_r,    cnt_nx;
  logic [PTR_W-1:0] ptr_r,    ptr_nx;
  logic             err_nx;

  logic [NREQ-1:0]  ack_r;
  logic             err_r;
  logic             busy_r;
  logic             cur_src_r;

  logic             found_s;
  logic [PTR_W-1:0] pick_s;
  logic             new_act_s;
  logic             old_act_s;

  // Bring the asynchronous mux active flags into the reference clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act0_sync_r <= {SYNC_STAGES{1'b0}};
      act1_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      act0_sync_r <= {act0_sync_r[SYNC_STAGES-2:0], act0};
      act1_sync_r <= {act1_sync_r[SYNC_STAGES-2:0], act1};
    end
  end

  assign act0_s = act0_sync_r[SYNC_STAGES-1];
  assign act1_s = act1_sync_r[SYNC_STAGES-1];

  // Running source tracks whichever single path is active; otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_src_r <= 1'b0;
    end else if (act0_s && !act1_s) begin
      cur_src_r <= 1'b1;
    end else if (act1_s && !act0_s) begin
      cur_src_r <= 1'b0;
    end else begin
      cur_src_r <= cur_src_r;
    end
  end

  // Round-robin pick: first request at or above the pointer, then wrap to 0.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {PTR_W{1'b0}};
    for (int j = 0; j < NREQ; j++) begin
      if (!found_s && req[j] && (PTR_W'(j) >= ptr_r)) begin
        found_s = 1'b1;
        pick_s  = PTR_W'(j);
      end else begin
        found_s = found_s;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found_s && req[j]) begin
        found_s = 1'b1;
        pick_s  = PTR_W'(j);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign new_act_s = src_active(tgt_r, act0_s, act1_s);
  assign old_act_s = src_active(~tgt_r, act0_s, act1_s);

  // Next-state logic for the switch sequencer.
  always_comb begin
    state_nx  = state_r;
    select_nx = select_r;
    gnt_nx    = gnt_r;
    tgt_nx    = tgt_r;
    cnt_nx    = cnt_r;
    ptr_nx    = ptr_r;
    err_nx    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          gnt_nx = pick_s;
          tgt_nx = req_tgt[pick_s];
          if ((req_tgt[pick_s] == select_r) &&
              src_active(req_tgt[pick_s], act0_s, act1_s)) begin
            // Already running the requested source: acknowledge only.
            state_nx = ST_ACK;
          end else begin
            select_nx = req_tgt[pick_s];
            cnt_nx    = {CNT_W{1'b0}};
            state_nx  = ST_BREAK;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_BREAK: begin
        if (!old_act_s) begin
          cnt_nx   = {CNT_W{1'b0}};
          state_nx = ST_MAKE;
        end else if (cnt_r == TIMEOUT_C) begin
          err_nx   = 1'b1;
          state_nx = ST_ACK;
        end else begin
          cnt_nx = cnt_r + CNT_W'(1);
        end
      end
      ST_MAKE: begin
        if (new_act_s) begin
          state_nx = ST_ACK;
        end else if (cnt_r == TIMEOUT_C) begin
          err_nx   = 1'b1;
          state_nx = ST_ACK;
        end else begin
          cnt_nx = cnt_r + CNT_W'(1);
        end
      end
      ST_ACK: begin
        ptr_nx   = (gnt_r == LAST_IDX) ? {PTR_W{1'b0}} : gnt_r + PTR_W'(1);
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State, select, grant and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      select_r <= 1'b0;
      gnt_r    <= {PTR_W{1'b0}};
      tgt_r    <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      ptr_r    <= {PTR_W{1'b0}};
    end else begin
      state_r  <= state_nx;
      select_r <= select_nx;
      gnt_r    <= gnt_nx;
      tgt_r    <= tgt_nx;
      cnt_r    <= cnt_nx;
      ptr_r    <= ptr_nx;
    end
  end

  // Outputs registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r  <= {NREQ{1'b0}};
      err_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      ack_r  <= (state_nx == ST_ACK) ? onehot(gnt_nx) : {NREQ{1'b0}};
      err_r  <= err_nx;
      busy_r <= (state_nx != ST_IDLE);
    end
  end

  assign select  = select_r;
  assign ack     = ack_r;
  assign err     = err_r;
  assign busy    = busy_r;
  assign cur_src = cur_src_r;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Testbench for clk_switch_ctrl: behavioural mux model, scoreboard of
// expected acks, a table of single-request vectors and hand-written
// multi-cycle sequences (round-robin, reset mid-switch, timeout).

module tb_clk_switch_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] req_tgt;
  logic       act0;
  logic       act1;
  logic       select;
  logic [3:0] ack;
  logic       err;
  logic       busy;
  logic       cur_src;

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct packed {
    logic [3:0] ack;
    logic       err;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    string      name;
    logic [3:0] req;
    logic [3:0] tgt;
    logic [3:0] exp_ack;
    logic       exp_err;
    int         exp_lat;
    logic       exp_sel;
    logic       exp_cur;
  } vec_t;
  vec_t vecs[4];

  // mux model state: m_src 1 = clk0 running
  logic m_src;
  int   m_phase;
  int   m_cnt;
  logic stuck;

  clk_switch_ctrl #(
    .NREQ(4), .SYNC_STAGES(2), .TIMEOUT(255), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_tgt(req_tgt),
    .act0(act0), .act1(act1), .select(select), .ack(ack),
    .err(err), .busy(busy), .cur_src(cur_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    end
  endtask

  // Break-before-make mux model: old path drops 3 cycles after select moves,
  // new path rises 4 cycles later. 'stuck' freezes it.
  always @(negedge clk) begin
    if (!stuck) begin
      case (m_phase)
        0: if (select !== m_src) begin m_phase = 1; m_cnt = 0; end
        1: begin
          m_cnt++;
          if (m_cnt == 3) begin
            if (m_src) act0 = 1'b0; else act1 = 1'b0;
            m_phase = 2; m_cnt = 0;
          end
        end
        2: begin
          m_cnt++;
          if (m_cnt == 4) begin
            m_src = select;
            if (m_src) act0 = 1'b1; else act1 = 1'b1;
            m_phase = 0;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Scoreboard: every ack pops one expected record.
  always @(negedge clk) begin
    exp_t e;
    if (ack !== 4'b0000) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", 32'(ack), 32'(0));
      end else begin
        e = sb_q.pop_front();
        check("ack", 32'(ack), 32'(e.ack));
        check("err", 32'(err), 32'(e.err));
      end
    end else if (err !== 1'b0) begin
      check("err_without_ack", 32'(err), 32'(0));
    end
  end

  task automatic wait_ack(input int bound, output int lat, output logic got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < bound) begin
      @(negedge clk);
      lat++;
      if (ack !== 4'b0000) got = 1'b1;
    end
  endtask

  task automatic run_req(input string name, input logic [3:0] r, input logic [3:0] t,
                         input logic [3:0] ea, input logic ee, input int elat, input int bound);
    int   lat;
    logic got;
    @(negedge clk);
    req_tgt = t;
    req     = r;
    sb_q.push_back('{ack: ea, err: ee});
    wait_ack(bound, lat, got);
    check({name, "_ack_seen"}, 32'(got), 32'(1));
    if (elat > 0) check({name, "_latency"}, 32'(lat), 32'(elat));
    req = 4'b0000;
  endtask

  initial begin
    int   lat;
    logic got;
    vecs[0] = '{"sw_clk0",   4'b0001, 4'b0001, 4'b0001, 1'b0, 11, 1'b1, 1'b1};
    vecs[1] = '{"noop_clk0", 4'b0100, 4'b0100, 4'b0100, 1'b0,  1, 1'b1, 1'b1};
    vecs[2] = '{"sw_clk1",   4'b0010, 4'b0000, 4'b0010, 1'b0, 11, 1'b0, 1'b0};
    vecs[3] = '{"noop_clk1", 4'b1000, 4'b0000, 4'b1000, 1'b0,  1, 1'b0, 1'b0};

    rst = 1'b1;
    req = 4'b0000; req_tgt = 4'b0000;
    act0 = 1'b0; act1 = 1'b1;
    m_src = 1'b0; m_phase = 0; m_cnt = 0; stuck = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_select",  32'(select),  32'(0));
    check("rst_ack",     32'(ack),     32'(0));
    check("rst_err",     32'(err),     32'(0));
    check("rst_busy",    32'(busy),    32'(0));
    check("rst_cur_src", 32'(cur_src), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_cur_src", 32'(cur_src), 32'(0));

    // table of single-request operations
    for (int i = 0; i < 4; i++) begin
      run_req(vecs[i].name, vecs[i].req, vecs[i].tgt, vecs[i].exp_ack,
              vecs[i].exp_err, vecs[i].exp_lat, 60);
      repeat (3) @(negedge clk);
      check({vecs[i].name, "_select"},  32'(select),  32'(vecs[i].exp_sel));
      check({vecs[i].name, "_cur_src"}, 32'(cur_src), 32'(vecs[i].exp_cur));
      check({vecs[i].name, "_busy"},    32'(busy),    32'(0));
    end

    // round-robin with pointer at 0: 1011 -> 0,1,3
    @(negedge clk);
    req_tgt = 4'b0000;
    req     = 4'b1011;
    sb_q.push_back('{ack: 4'b0001, err: 1'b0});
    sb_q.push_back('{ack: 4'b0010, err: 1'b0});
    sb_q.push_back('{ack: 4'b1000, err: 1'b0});
    for (int k = 0; k < 3; k++) begin
      wait_ack(20, lat, got);
      check("rr1_ack_seen", 32'(got), 32'(1));
      req = req & ~ack;
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);
    // pointer wrapped after 3: 0011 -> 0,1
    req     = 4'b0011;
    sb_q.push_back('{ack: 4'b0001, err: 1'b0});
    sb_q.push_back('{ack: 4'b0010, err: 1'b0});
    for (int k = 0; k < 2; k++) begin
      wait_ack(20, lat, got);
      check("rr2_ack_seen", 32'(got), 32'(1));
      req = req & ~ack;
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);
    check("rr_select", 32'(select), 32'(0));

    // reset during BREAK: select back to 0 at once, no ack
    @(negedge clk);
    req_tgt = 4'b0100;
    req     = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    check("midrst_busy_before",   32'(busy),   32'(1));
    check("midrst_select_before", 32'(select), 32'(1));
    rst = 1'b1;
    #1;
    check("midrst_select", 32'(select), 32'(0));
    check("midrst_busy",   32'(busy),   32'(0));
    check("midrst_ack",    32'(ack),    32'(0));
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_settle_cur_src", 32'(cur_src), 32'(0));
    check("midrst_settle_select",  32'(select),  32'(0));

    // post-reset requests serviced normally
    run_req("post_rst_sw_clk0", 4'b1000, 4'b1000, 4'b1000, 1'b0, 11, 60);
    repeat (3) @(negedge clk);
    check("post_rst_sw_clk0_cur", 32'(cur_src), 32'(1));
    run_req("post_rst_sw_clk1", 4'b0010, 4'b0000, 4'b0010, 1'b0, 11, 60);
    repeat (3) @(negedge clk);
    check("post_rst_sw_clk1_cur", 32'(cur_src), 32'(0));

    // timeout: act1 stuck high while switching to clk0
    stuck = 1'b1;
    run_req("timeout", 4'b0001, 4'b0001, 4'b0001, 1'b1, 257, 400);
    check("timeout_select", 32'(select), 32'(1));
    @(negedge clk);
    check("timeout_busy_after", 32'(busy), 32'(0));
    check("timeout_select_after", 32'(select), 32'(1));
    stuck = 1'b0;
    repeat (20) @(negedge clk);
    check("recover_cur_src", 32'(cur_src), 32'(1));

    check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
- Sequences the two-input glitch-free clock mux (select, per-source active flags out00/out01).
- Arbitrates clock-source switch requests from NREQ requesters (power manager, SW regs, test) round-robin.
- Drives the mux select and tracks the break-before-make handover via synchronized active flags.
- Acknowledges each request, with error on timeout. Runs on an always-on reference clock.

Parameters:
NREQ, 4, number of requesters
SYNC_STAGES, 2, synchronizer depth for mux active flags (>=2)
TIMEOUT, 255, max cycles per wait state before error
CNT_W, 8, timeout counter width (2^CNT_W > TIMEOUT)

Ports:
clk  in  1  always-on reference clock, rising edge
rst  in  1  asynchronous, active-high reset
req  in  NREQ  level request per requester; hold until ack
req_tgt  in  NREQ  per-requester target: 1 = clk0 source (select=1), 0 = clk1 source (select=0)
act0  in  1  mux clk0-path active flag (out00), asynchronous to clk
act1  in  1  mux clk1-path active flag (out01), asynchronous to clk
select  out  1  registered select to mux
ack  out  NREQ  one-cycle done pulse, one-hot, to granted requester
err  out  1  one-cycle pulse coincident with ack when the switch timed out
busy  out  1  high whenever state != IDLE
cur_src  out  1  1 = clk0 running, 0 = clk1 running (from synchronized flags)

Behaviour:
- Reset (async, immediate): state IDLE, select=0, ack=0, err=0, busy=0, cur_src=0, rr pointer=0, counter=0, sync flops=0.
- act0/act1 each pass SYNC_STAGES flops -> act0_s/act1_s. No other use of raw flags.
- cur_src: 1 when act0_s=1; 0 when act1_s=1; holds last value when both 0. Both 1 never legal; on both 1, hold.
- Arbitration (IDLE only): grant g = first asserted req at or after rr pointer, wrapping NREQ-1 -> 0. Latch g and tgt=req_tgt[g]. Pointer <= g+1 (mod NREQ) when state leaves ACK.
- FSM, one transition per clk edge:
  IDLE: no req -> stay. Req with tgt==select and act_s[tgt]=1 -> ACK (no-op switch, select unchanged). Otherwise select<=tgt, counter<=0 -> BREAK.
  BREAK: wait act_s[old]=0 (old = ~tgt). Then counter<=0 -> MAKE. Else counter++; counter==TIMEOUT -> ACK with err flag set.
  MAKE: wait act_s[tgt]=1 -> ACK. Else counter++; counter==TIMEOUT -> ACK with err flag.
  ACK: ack[g]=1, err=err flag for exactly this cycle; clear err flag; -> IDLE.
- ack/err/busy decoded from registered state. Ack high for the cycle after the edge on which the FSM enters ACK.
- Latency: raw act_tgt rise before edge k -> MAKE exits at edge k+SYNC_STAGES -> ack high during cycle following that edge. No-op request: ack 1 cycle after req sampled.
- select changes only on IDLE->BREAK. On timeout, select keeps tgt; no retry, no revert.
- req dropped mid-operation: switch completes, ack still pulsed. req held after ack: re-arbitrated next IDLE cycle (resolves as no-op).
- req_tgt only sampled at grant; later changes ignored until next grant.
- Simultaneous requests: one served per operation; the rest wait, order by round-robin.
- Reset mid-operation: select->0 immediately; in-flight request lost, no ack. Requester re-requests.

Test Plan:
- Reset: rst=1 -> select=0, ack=0, err=0, busy=0, cur_src=0. Release with act1 model -> cur_src=0 after 2 cycles.
- Switch to clk0: req[0]=1, req_tgt[0]=1. Mux model drops act1 3 cycles after select=1, raises act0 4 cycles later. Expect BREAK->MAKE->ACK, ack=4'b0001 one cycle, err=0, cur_src=1.
- No-op: with clk0 active, req[2]=1, tgt=1 -> ack=4'b0100 one cycle after req sampled, select stays 1, never BREAK.
- Round-robin: req=4'b1011 held, each released after its ack, pointer=0 -> ack order 0,1,3. Then req=4'b0011 with pointer=0 (wrapped after 3) -> order 0,1.
- Timeout: act1 stuck 1, request tgt=1, TIMEOUT=255 -> err=1 with ack 256 cycles after BREAK entry. select stays 1, busy=0 after.
- Reset mid-BREAK: assert rst during BREAK -> select=0 same cycle, no ack. Post-reset request serviced normally.
